// File: rtl/secure_start_ctrl.sv
// secure_start_ctrl
//   Upstream controller for the secure start/done stage. A request carries a
//   key that is checked against UNLOCK_KEY. On a match the block raises
//   secure, pulses start for one cycle and waits for done, giving up after
//   TIMEOUT cycles. MAX_FAIL consecutive key mismatches lock the block out
//   for LOCK_CYCLES cycles.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/req_key request handshake input and its key
//   req_ready         high while a request can be accepted (IDLE)
//   secure, start     downstream controls (start is a one-cycle pulse)
//   done              downstream completion, only honoured while waiting
//   busy              transaction in progress (CHECK/START/WAIT)
//   grant_ok          pulse: downstream completed
//   err_auth          pulse: key mismatch
//   err_timeout       pulse: done not seen in time
//   locked            block is in lockout
//   fail_cnt          consecutive authentication failure count
module secure_start_ctrl #(
    parameter int unsigned       KEY_W       = 8,
    parameter logic [KEY_W-1:0]  UNLOCK_KEY  = 8'hA5,
    parameter int unsigned       MAX_FAIL    = 3,
    parameter int unsigned       TIMEOUT     = 16,
    parameter int unsigned       LOCK_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic [KEY_W-1:0]               req_key,
    output logic                           req_ready,
    output logic                           secure,
    output logic                           start,
    input  logic                           done,
    output logic                           busy,
    output logic                           grant_ok,
    output logic                           err_auth,
    output logic                           err_timeout,
    output logic                           locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

    localparam int unsigned FC_W  = $clog2(MAX_FAIL + 1);
    // +1 keeps the widths non-zero for the minimum legal parameter values
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [FC_W-1:0]  FAIL_MAX = FC_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_START,
        ST_WAIT,
        ST_LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [FC_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic               grant_ok_q, grant_ok_d;
    logic               err_auth_q, err_auth_d;
    logic               err_timeout_q, err_timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            key_q         <= '0;
            timer_q       <= '0;
            lock_cnt_q    <= '0;
            fail_cnt_q    <= '0;
            grant_ok_q    <= 1'b0;
            err_auth_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            timer_q       <= timer_d;
            lock_cnt_q    <= lock_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
            grant_ok_q    <= grant_ok_d;
            err_auth_q    <= err_auth_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        timer_d       = timer_q;
        lock_cnt_d    = lock_cnt_q;
        fail_cnt_d    = fail_cnt_q;
        grant_ok_d    = 1'b0;
        err_auth_d    = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    key_d   = req_key;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (key_q == UNLOCK_KEY) begin
                    fail_cnt_d = '0;
                    state_d    = ST_START;
                end else begin
                    err_auth_d = 1'b1;
                    // fail_cnt never exceeds MAX_FAIL-1 here, so +1 cannot overflow
                    if (fail_cnt_q + FC_W'(1) == FAIL_MAX) begin
                        fail_cnt_d = FAIL_MAX;
                        lock_cnt_d = '0;
                        state_d    = ST_LOCK;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FC_W'(1);
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // done wins over an expiring timer in the same cycle
                if (done) begin
                    grant_ok_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_LOCK: begin
                if (lock_cnt_q == LCK_LAST) begin
                    fail_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so the asynchronous
    // reset drops secure/start without waiting for a clock edge.
    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_CHECK) || (state_q == ST_START) || (state_q == ST_WAIT);
    assign secure      = (state_q == ST_START) || (state_q == ST_WAIT);
    assign start       = (state_q == ST_START);
    assign locked      = (state_q == ST_LOCK);
    assign grant_ok    = grant_ok_q;
    assign err_auth    = err_auth_q;
    assign err_timeout = err_timeout_q;
    assign fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_secure_start_ctrl.sv
// tb_secure_start_ctrl
//   Cycle-level checker for secure_start_ctrl. Inputs are driven on the
//   falling edge; every output is compared on the falling edge against a
//   behavioural model that tracks "cycles since the request was accepted"
//   and "lockout cycles remaining" instead of an explicit state machine.
//   A small downstream model answers start with done after a set delay.
module tb_secure_start_ctrl;

    localparam int unsigned KEY_W       = 8;
    localparam logic [7:0]  UNLOCK_KEY  = 8'hA5;
    localparam int unsigned MAX_FAIL    = 3;
    localparam int unsigned TIMEOUT     = 16;
    localparam int unsigned LOCK_CYCLES = 32;
    localparam int unsigned FC_W        = $clog2(MAX_FAIL + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [KEY_W-1:0] req_key;
    logic             req_ready;
    logic             secure;
    logic             start;
    logic             done;
    logic             busy;
    logic             grant_ok;
    logic             err_auth;
    logic             err_timeout;
    logic             locked;
    logic [FC_W-1:0]  fail_cnt;

    always #5 clk = ~clk;

    secure_start_ctrl #(
        .KEY_W       (KEY_W),
        .UNLOCK_KEY  (UNLOCK_KEY),
        .MAX_FAIL    (MAX_FAIL),
        .TIMEOUT     (TIMEOUT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_key     (req_key),
        .req_ready   (req_ready),
        .secure      (secure),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .grant_ok    (grant_ok),
        .err_auth    (err_auth),
        .err_timeout (err_timeout),
        .locked      (locked),
        .fail_cnt    (fail_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_age: 0 = not in a transaction, 1 = key check, 2 = start cycle,
    //        3.. = waiting (waited cycles = m_age-3)
    // m_lock_left: lockout cycles still to go (0 = not locked)
    // m_pulse: event to report this cycle (0 none, 1 grant, 2 auth, 3 timeout)
    int         m_age;
    int         m_lock_left;
    int         m_fails;
    int         m_pulse;
    logic [7:0] m_key;

    task automatic m_reset();
        m_age = 0; m_lock_left = 0; m_fails = 0; m_pulse = 0; m_key = '0;
    endtask

    task automatic m_advance(input logic v, input logic [7:0] k, input logic d);
        m_pulse = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_age == 0) begin
            if (v) begin
                m_key = k;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            if (m_key == UNLOCK_KEY) begin
                m_fails = 0;
                m_age   = 2;
            end else begin
                m_pulse = 2;
                m_age   = 0;
                m_fails++;
                if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYCLES;
            end
        end else if (m_age == 2) begin
            m_age = 3;
        end else begin
            if (d) begin
                m_pulse = 1;
                m_age   = 0;
            end else if (m_age - 3 == TIMEOUT - 1) begin
                m_pulse = 3;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("req_ready",   32'(req_ready),   32'(m_age == 0 && m_lock_left == 0));
        chk("busy",        32'(busy),        32'(m_age > 0));
        chk("secure",      32'(secure),      32'(m_age >= 2));
        chk("start",       32'(start),       32'(m_age == 2));
        chk("locked",      32'(locked),      32'(m_lock_left > 0));
        chk("grant_ok",    32'(grant_ok),    32'(m_pulse == 1));
        chk("err_auth",    32'(err_auth),    32'(m_pulse == 2));
        chk("err_timeout", 32'(err_timeout), 32'(m_pulse == 3));
        chk("fail_cnt",    32'(fail_cnt),    32'(m_fails));
    endtask

    // ---------------- downstream responder ----------------
    // ds_delay cycles after seeing start it raises done for one cycle
    // (0 = never answers). delay 2 matches the start->S1->S2 downstream FSM.
    int ds_delay = 2;
    int ds_cnt   = 0;

    // One clock cycle: check outputs, then drive the inputs for this cycle.
    task automatic step(input logic v, input logic [7:0] k, input logic inject_done);
        logic d;
        @(negedge clk);
        check_outputs();
        d = 1'b0;
        if (ds_cnt > 0) begin
            ds_cnt--;
            d = (ds_cnt == 0);
        end
        if (start && ds_delay > 0) ds_cnt = ds_delay;
        d = d | inject_done;
        req_valid = v;
        req_key   = k;
        done      = d;
        m_advance(v, k, d);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_key = '0; done = 1'b0;
        m_reset();
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_secure",    32'(secure),    32'd0);
        chk("rst_start",     32'(start),     32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_fail_cnt",  32'(fail_cnt),  32'd0);
        #10 rst_n = 1'b1;

        // good key against the 3-state downstream FSM
        ds_delay = 2;
        step(1'b1, UNLOCK_KEY, 1'b0);
        repeat (7) step(1'b0, 8'h00, 1'b0);

        // three bad keys with req_valid held through the lockout
        repeat (2 * MAX_FAIL + LOCK_CYCLES + 3) step(1'b1, 8'h00, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // two bad keys then a good one
        repeat (4) step(1'b1, 8'h00, 1'b0);
        step(1'b1, UNLOCK_KEY, 1'b0);
        repeat (7) step(1'b0, 8'h00, 1'b0);

        // one bad key so fail_cnt is non-zero, then a timeout with done
        // injected in IDLE afterwards
        step(1'b1, 8'h3C, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        ds_delay = 0;
        step(1'b1, UNLOCK_KEY, 1'b0);
        for (int i = 0; i < TIMEOUT + 6; i++) step(1'b0, 8'h00, i >= TIMEOUT + 3);

        // done arrives exactly when the timer reaches TIMEOUT-1
        ds_delay = TIMEOUT;
        step(1'b1, UNLOCK_KEY, 1'b0);
        repeat (TIMEOUT + 4) step(1'b0, 8'h00, 1'b0);

        // asynchronous reset in the middle of WAIT
        ds_delay = 0;
        step(1'b1, UNLOCK_KEY, 1'b0);
        repeat (6) step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_outputs();
        chk("pre_rst_secure", 32'(secure), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_secure",    32'(secure),    32'd0);
        chk("async_start",     32'(start),     32'd0);
        chk("async_busy",      32'(busy),      32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd1);
        chk("async_fail_cnt",  32'(fail_cnt),  32'd0);
        m_reset();
        ds_cnt = 0;
        req_valid = 1'b0; done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 8'h00, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] k;
            if (i % 60 == 0) begin
                ds_delay = int'($urandom_range(0, TIMEOUT + 3));
                if (ds_delay == 1) ds_delay = 2;
            end
            v = ($urandom_range(0, 2) != 0);
            k = ($urandom_range(0, 1) != 0) ? UNLOCK_KEY : 8'($urandom);
            step(v, k, $urandom_range(0, 11) == 0);
        end
        step(1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
